exception_ctrl: RTL and testbench

- CP0 exception/interrupt sequencer that sits at the write-back end of the five-stage pipeline.
- Consumes the exception, CP0 and eret flags delivered by the MEM/WB pipeline register, plus external interrupt lines.
- Prioritises one event per cycle, updates the Status/Cause/EPC registers, and drives a multi-cycle flush to every pipeline register.
- Drives a one-cycle PC redirect to the handler, or to EPC on eret.

---
 rtl/exception_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_exception_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// exception_ctrl: CP0 exception/interrupt sequencer at the write-back end of
// the pipeline. Picks at most one event per cycle (exception, eret or
// interrupt), updates Status/Cause/EPC, and drives a FLUSH_CYCLES-wide
// pipeline flush with a one-cycle PC redirect to the handler or to EPC.
module exception_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_F500,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_overflow,
    input  logic        wb_divide_zero,
    input  logic        wb_syscall,
    input  logic        wb_break,
    input  logic        wb_reserved_instruction,
    input  logic        wb_eret,
    input  logic        wb_mtc0,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_opcplus4,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_rt_value,
    input  logic [5:0]  ext_int,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        back_from_eret,
    output logic [31:0] cp0_rdata,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc
);

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_DIVZ = 5'd7;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BRK  = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [4:0] IDX_STATUS = 5'd12;
    localparam logic [4:0] IDX_CAUSE  = 5'd13;
    localparam logic [4:0] IDX_EPC    = 5'd14;

    // Counter start value: the entry cycle counts as the first flush cycle.
    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_ie;
    logic        r_exl;
    logic [5:0]  r_im;
    logic [4:0]  r_exc_code;
    logic [1:0]  r_sw;
    logic [5:0]  r_ip;
    logic [31:0] r_epc;
    logic        r_flush;
    logic        r_pc_redirect;
    logic [31:0] r_redirect_pc;
    logic        r_back_from_eret;

    logic        w_idle;
    logic        w_sync_exc;
    logic [4:0]  w_exc_code;
    logic        w_take_exc;
    logic        w_take_eret;
    logic        w_take_int;
    logic        w_mtc0;

    // Event decode and exception priority (reserved instruction highest).
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_exc_code = EXC_INT;
        if (wb_reserved_instruction) begin
            w_exc_code = EXC_RI;
        end else if (wb_overflow) begin
            w_exc_code = EXC_OV;
        end else if (wb_divide_zero) begin
            w_exc_code = EXC_DIVZ;
        end else if (wb_syscall) begin
            w_exc_code = EXC_SYS;
        end else if (wb_break) begin
            w_exc_code = EXC_BRK;
        end

        w_idle      = (r_state == S_IDLE);
        w_sync_exc  = wb_valid & (wb_reserved_instruction | wb_overflow |
                                  wb_divide_zero | wb_syscall | wb_break);
        w_take_exc  = w_idle & w_sync_exc;
        w_take_eret = w_idle & wb_valid & wb_eret & ~w_sync_exc;
        // Interrupt uses the pre-write IE/IM/EXL, so a same-edge mtc0 to
        // status only takes effect from the following cycle.
        w_take_int  = w_idle & r_ie & ~r_exl & (|(ext_int & r_im)) &
                      ~w_sync_exc & ~(wb_valid & wb_eret);
        w_mtc0      = w_idle & wb_valid & wb_mtc0 & ~w_sync_exc;
    end

    // CP0 register updates, event sequencing and registered flush/redirect.
    // NOTE: sequential state uses non-blocking assignments only; the event
    // updates below deliberately come after the mtc0 writes so that an
    // event on the same edge overrides the register fields it owns.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_ie             <= 1'b0;
            r_exl            <= 1'b0;
            r_im             <= '0;
            r_exc_code       <= '0;
            r_sw             <= '0;
            r_ip             <= '0;
            r_epc            <= '0;
            r_flush          <= 1'b0;
            r_pc_redirect    <= 1'b0;
            r_redirect_pc    <= '0;
            r_back_from_eret <= 1'b0;
        end else begin
            r_ip             <= ext_int;
            r_pc_redirect    <= 1'b0;
            r_back_from_eret <= 1'b0;

            if (w_mtc0) begin
                case (wb_rd)
                    IDX_STATUS: begin
                        r_im  <= wb_rt_value[15:10];
                        r_exl <= wb_rt_value[1];
                        r_ie  <= wb_rt_value[0];
                    end
                    IDX_CAUSE: r_sw  <= wb_rt_value[9:8];
                    IDX_EPC:   r_epc <= wb_rt_value;
                    default: ;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (w_take_exc || w_take_int || w_take_eret) begin
                        r_state       <= S_FLUSH;
                        r_cnt         <= CNT_INIT;
                        r_flush       <= 1'b1;
                        r_pc_redirect <= 1'b1;
                    end
                    if (w_take_exc) begin
                        r_epc         <= wb_pc;
                        r_exc_code    <= w_exc_code;
                        r_exl         <= 1'b1;
                        r_redirect_pc <= HANDLER_ADDR;
                    end else if (w_take_int) begin
                        if (wb_valid) begin
                            r_epc <= wb_opcplus4;
                        end
                        r_exc_code    <= EXC_INT;
                        r_exl         <= 1'b1;
                        r_redirect_pc <= HANDLER_ADDR;
                    end else if (w_take_eret) begin
                        r_exl            <= 1'b0;
                        r_redirect_pc    <= r_epc;
                        r_back_from_eret <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_IDLE;
                        r_flush <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    // Architectural register images and combinational mfc0 read port.
    always_comb begin
        status         = 32'd0;
        status[15:10]  = r_im;
        status[1]      = r_exl;
        status[0]      = r_ie;

        cause          = 32'd0;
        cause[15:10]   = r_ip;
        cause[9:8]     = r_sw;
        cause[6:2]     = r_exc_code;

        epc            = r_epc;

        case (wb_rd)
            IDX_STATUS: cp0_rdata = status;
            IDX_CAUSE:  cp0_rdata = cause;
            IDX_EPC:    cp0_rdata = r_epc;
            default:    cp0_rdata = 32'd0;
        endcase
    end

    assign flush          = r_flush;
    assign pc_redirect    = r_pc_redirect;
    assign redirect_pc    = r_redirect_pc;
    assign back_from_eret = r_back_from_eret;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed stimulus for exception_ctrl. Each expected
// redirect is pushed into a queue when issued; a monitor pops and compares
// whenever the DUT presents pc_redirect, and checks every flush pulse width.
module tb_exception_ctrl;

    localparam logic [31:0] HANDLER      = 32'h0000_F500;
    localparam int          FLUSH_CYCLES = 2;

    typedef struct {
        logic [31:0] target;
        logic        eret;
        logic [31:0] epc;
        logic [4:0]  code;
        logic        exl;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_overflow;
    logic        wb_divide_zero;
    logic        wb_syscall;
    logic        wb_break;
    logic        wb_reserved_instruction;
    logic        wb_eret;
    logic        wb_mtc0;
    logic [31:0] wb_pc;
    logic [31:0] wb_opcplus4;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rt_value;
    logic [5:0]  ext_int;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        back_from_eret;
    logic [31:0] cp0_rdata;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    exception_ctrl #(
        .HANDLER_ADDR (HANDLER),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .wb_valid                (wb_valid),
        .wb_overflow             (wb_overflow),
        .wb_divide_zero          (wb_divide_zero),
        .wb_syscall              (wb_syscall),
        .wb_break                (wb_break),
        .wb_reserved_instruction (wb_reserved_instruction),
        .wb_eret                 (wb_eret),
        .wb_mtc0                 (wb_mtc0),
        .wb_pc                   (wb_pc),
        .wb_opcplus4             (wb_opcplus4),
        .wb_rd                   (wb_rd),
        .wb_rt_value             (wb_rt_value),
        .ext_int                 (ext_int),
        .flush                   (flush),
        .pc_redirect             (pc_redirect),
        .redirect_pc             (redirect_pc),
        .back_from_eret          (back_from_eret),
        .cp0_rdata               (cp0_rdata),
        .status                  (status),
        .cause                   (cause),
        .epc                     (epc)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        wb_valid                = 1'b0;
        wb_overflow             = 1'b0;
        wb_divide_zero          = 1'b0;
        wb_syscall              = 1'b0;
        wb_break                = 1'b0;
        wb_reserved_instruction = 1'b0;
        wb_eret                 = 1'b0;
        wb_mtc0                 = 1'b0;
        wb_pc                   = 32'd0;
        wb_opcplus4             = 32'd0;
        wb_rd                   = 5'd0;
        wb_rt_value             = 32'd0;
    endtask

    task automatic push_exp(input logic [31:0] target, input logic eret,
                            input logic [31:0] e_epc, input logic [4:0] code,
                            input logic exl);
        exp_t e;
        e.target = target;
        e.eret   = eret;
        e.epc    = e_epc;
        e.code   = code;
        e.exl    = exl;
        exp_q.push_back(e);
    endtask

    // One-cycle mtc0 write, driven between falling edges.
    task automatic mtc0(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clock);
        wb_valid    = 1'b1;
        wb_mtc0     = 1'b1;
        wb_rd       = idx;
        wb_rt_value = val;
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic mfc0_check(input string name, input logic [4:0] idx, input logic [31:0] exp);
        wb_rd = idx;
        #1;
        check(name, cp0_rdata, exp);
        wb_rd = 5'd0;
    endtask

    // Monitor: pops one expectation per redirect and measures flush widths.
    initial begin : monitor
        int  run;
        logic prev_redirect;
        exp_t e;
        run = 0;
        prev_redirect = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                run = 0;
                prev_redirect = 1'b0;
            end else begin
                if (flush) begin
                    run++;
                end else if (run != 0) begin
                    check("flush_width", 32'(run), 32'(FLUSH_CYCLES));
                    run = 0;
                end
                if (back_from_eret && !pc_redirect) begin
                    check("eret_strobe_without_redirect", {31'd0, back_from_eret}, 32'd0);
                end
                if (pc_redirect) begin
                    check("redirect_one_cycle", {31'd0, prev_redirect}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_redirect", redirect_pc, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("redirect_pc",    redirect_pc, e.target);
                        check("back_from_eret", {31'd0, back_from_eret}, {31'd0, e.eret});
                        check("flush_at_redirect", {31'd0, flush}, 32'd1);
                        check("epc",            epc, e.epc);
                        check("exc_code",       {27'd0, cause[6:2]}, {27'd0, e.code});
                        check("status_exl",     {31'd0, status[1]}, {31'd0, e.exl});
                    end
                end
                prev_redirect = pc_redirect;
            end
        end
    end

    initial begin : stimulus
        reset   = 1'b1;
        ext_int = 6'd0;
        clear_inputs();
        #12;
        check("rst_flush",       {31'd0, flush}, 32'd0);
        check("rst_pc_redirect", {31'd0, pc_redirect}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_back_eret",   {31'd0, back_from_eret}, 32'd0);
        check("rst_status",      status, 32'd0);
        check("rst_cause",       cause, 32'd0);
        check("rst_epc",         epc, 32'd0);
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;

        // Overflow exception.
        @(negedge clock);
        wb_valid = 1'b1; wb_overflow = 1'b1;
        wb_pc = 32'h100; wb_opcplus4 = 32'h104;
        push_exp(HANDLER, 1'b0, 32'h100, 5'd12, 1'b1);
        @(negedge clock);
        clear_inputs();
        repeat (4) @(negedge clock);
        mfc0_check("mfc0_epc_after_ov", 5'd14, 32'h100);

        // Syscall and reserved instruction together: reserved wins (EXL=1 still).
        @(negedge clock);
        wb_valid = 1'b1; wb_syscall = 1'b1; wb_reserved_instruction = 1'b1;
        wb_pc = 32'h200; wb_opcplus4 = 32'h204;
        push_exp(HANDLER, 1'b0, 32'h200, 5'd10, 1'b1);
        @(negedge clock);
        clear_inputs();
        repeat (4) @(negedge clock);

        // mtc0 epc; mfc0 on the same cycle still sees the old value.
        @(negedge clock);
        wb_valid = 1'b1; wb_mtc0 = 1'b1; wb_rd = 5'd14; wb_rt_value = 32'h204;
        #1 check("mfc0_old_before_edge", cp0_rdata, 32'h200);
        @(negedge clock);
        clear_inputs();
        mfc0_check("mfc0_epc_written", 5'd14, 32'h204);

        // Eret back to EPC.
        @(negedge clock);
        wb_valid = 1'b1; wb_eret = 1'b1; wb_pc = 32'h210;
        push_exp(32'h204, 1'b1, 32'h204, 5'd10, 1'b0);
        @(negedge clock);
        clear_inputs();
        repeat (4) @(negedge clock);
        check("status_after_eret", status, 32'd0);

        // Enable interrupts, then raise ext_int[0].
        mtc0(5'd12, 32'h0000_0401);
        mfc0_check("mfc0_status_written", 5'd12, 32'h0000_0401);
        @(negedge clock);
        ext_int = 6'b000001;
        wb_valid = 1'b1; wb_pc = 32'h2C; wb_opcplus4 = 32'h30;
        push_exp(HANDLER, 1'b0, 32'h30, 5'd0, 1'b1);
        @(negedge clock);
        clear_inputs();
        repeat (6) @(negedge clock);
        check("cause_ip_latched", cause, 32'h0000_0400);
        check("status_exl_masks", status, 32'h0000_0403);
        ext_int = 6'd0;
        @(negedge clock);

        // Break during the flush window is ignored.
        @(negedge clock);
        wb_valid = 1'b1; wb_overflow = 1'b1; wb_pc = 32'h300; wb_opcplus4 = 32'h304;
        push_exp(HANDLER, 1'b0, 32'h300, 5'd12, 1'b1);
        @(negedge clock);
        clear_inputs();
        wb_valid = 1'b1; wb_break = 1'b1; wb_pc = 32'h400; wb_opcplus4 = 32'h404;
        repeat (2) @(negedge clock);
        clear_inputs();
        check("epc_kept_in_flush", epc, 32'h300);
        check("code_kept_in_flush", {27'd0, cause[6:2]}, 32'd12);
        repeat (2) @(negedge clock);

        // Back in IDLE: a syscall is taken.
        @(negedge clock);
        wb_valid = 1'b1; wb_syscall = 1'b1; wb_pc = 32'h500; wb_opcplus4 = 32'h504;
        push_exp(HANDLER, 1'b0, 32'h500, 5'd8, 1'b1);
        @(negedge clock);
        clear_inputs();
        repeat (4) @(negedge clock);

        // Divide-by-zero, then asynchronous reset inside the flush.
        @(negedge clock);
        wb_valid = 1'b1; wb_divide_zero = 1'b1; wb_pc = 32'h600; wb_opcplus4 = 32'h604;
        push_exp(HANDLER, 1'b0, 32'h600, 5'd7, 1'b1);
        @(negedge clock);
        clear_inputs();
        #2 reset = 1'b1;
        #1;
        check("arst_flush",       {31'd0, flush}, 32'd0);
        check("arst_pc_redirect", {31'd0, pc_redirect}, 32'd0);
        check("arst_status",      status, 32'd0);
        check("arst_cause",       cause, 32'd0);
        check("arst_epc",         epc, 32'd0);
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(negedge clock);
        check("no_redirect_after_reset", {31'd0, pc_redirect}, 32'd0);
        check("expected_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
